gpio_pkt_arbiter: RTL and testbench
===================================

Name: gpio_pkt_arbiter

Overview:
- Shares the single GPIO packet write path (dt_gpio_fifo_enable / dt_gpio_fifo_data into the GPIO peripheral) between NUM_REQ requesters.
- Typical requesters: host bridge, PWM sequencer, debug port.
- Round-robin arbitration with valid/ready handshakes.
- Guarantees a minimum idle gap between enable pulses so the downstream clk1-to-clk2 crossing is never overrun.
- Supports a bounded lock so one requester can issue an atomic multi-packet sequence.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_PACKET_WIDTH, 51: packet width; matches the GPIO peripheral input.
- GAP_CYCLES, 2: idle cycles forced after every enable pulse (0..15).
- LOCK_TIMEOUT, 64: maximum cycles a lock may be held before forced release (2..255).

Ports:
- clk1  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester packet valid.
- req_lock  in  NUM_REQ  per-requester lock request; sampled at grant.
- req_data  in  NUM_REQ*DATA_PACKET_WIDTH  packed packets; requester i at slice i.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- dt_gpio_fifo_full  in  1  downstream backpressure.
- dt_gpio_fifo_enable  out  1  single-cycle write strobe.
- dt_gpio_fifo_data  out  DATA_PACKET_WIDTH  registered packet.
- grant_id  out  clog2(NUM_REQ)  id of the last accepted requester.
- lock_active  out  1  lock currently held.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE.
  - All outputs 0, including dt_gpio_fifo_data.
  - RR pointer = NUM_REQ-1, so requester 0 has highest priority.
  - Lock cleared, timer cleared.
  - Reset mid-operation aborts any ISSUE or GAP immediately. A packet not yet strobed is dropped; its requester already saw ready.
- States: IDLE, ISSUE, GAP.
- IDLE:
  - Eligible set = req_valid, masked to lock owner only when lock_active.
  - If eligible is nonzero and dt_gpio_fifo_full=0: winner = first eligible after the RR pointer, wrapping around.
  - req_ready[winner]=1 combinationally in the same cycle.
  - At the edge: capture req_data[winner] into dt_gpio_fifo_data, set grant_id=winner, RR pointer=winner, go to ISSUE.
  - dt_gpio_fifo_full=1 blocks all grants; ready stays 0.
- ISSUE: dt_gpio_fifo_enable=1 for exactly one cycle. Then GAP if GAP_CYCLES>0, else IDLE.
- GAP: count GAP_CYCLES cycles, then IDLE.
- Throughput and latency:
  - Accept-to-enable latency is 1 cycle.
  - Minimum pulse spacing is GAP_CYCLES+2 cycles.
- Handshake rules:
  - A requester must hold req_valid and req_data stable until it sees req_ready.
  - req_valid must not depend on req_ready.
  - At most one req_ready bit is high per cycle.
- Lock:
  - If req_lock[winner]=1 at capture and no lock is active: set lock_active=1, owner=winner, timer=0.
  - The timer increments every cycle while locked, saturating.
  - Release (lock_active=0 on the next edge) when req_lock[owner]=0 or timer reaches LOCK_TIMEOUT-1.
  - If a release and a grant to the owner fall in the same cycle, the grant completes. Fairness then resumes from the owner's RR position.
- dt_gpio_fifo_data holds its last value between pulses.
- busy = (state != IDLE).

Optional Feature:
- Macro: PERIPLEX_ARB_STATS_EN.
- Defined: adds output stat_pkt_cnt (16 bits) and output stat_lock_to_cnt (8 bits).
  - stat_pkt_cnt increments on each dt_gpio_fifo_enable and saturates at 0xFFFF.
  - stat_lock_to_cnt increments on each timeout-forced release and saturates at 0xFF.
  - Both reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package periplex_arb_pkg holds:
  - arb_state_t enum (IDLE, ISSUE, GAP).
  - Function clog2_min1, returning grant width ≥1.
  - Constants STAT_PKT_W=16 and STAT_TO_W=8.
- One sub-module, rr_picker: purely combinational.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, grant index, any-request flag.
- The FSM, lock logic and gap counter stay in gpio_pkt_arbiter.

Test Plan:
1. Reset and single requester: reset held 3 cycles, all outputs 0. Then req_valid=4'b0010, data=0x1_2345 → req_ready=4'b0010 in the same cycle, enable pulse 1 cycle later with data 0x1_2345, grant_id=1.
2. Round-robin with GAP_CYCLES=2: req_valid=4'b1111 held → grants in order 0,1,2,3,0, with enable pulses exactly 4 cycles apart.
3. Backpressure: dt_gpio_fifo_full=1 while req_valid=4'b0001 for 10 cycles → no ready and no enable. Full drops → ready in that cycle, enable on the next.
4. Lock: requester 2 is granted with req_lock[2]=1 and sends 3 packets while req_valid=4'b1111 → grants 2,2,2. req_lock[2]=0 → next grant is 3.
5. Lock timeout with LOCK_TIMEOUT=8: owner 1 holds req_lock but drops valid → lock_active falls after 8 cycles, requester 0 is granted next, and stat_lock_to_cnt=1 when the feature is compiled in.
6. Reset mid-GAP: assert rst_n=0 during GAP → next cycle state=IDLE, busy=0, all outputs 0, and requester 0 has top priority.

Source files
------------

// File: rtl/periplex_arb_pkg.sv
// Shared types and helpers for the GPIO packet arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE, ISSUE, GAP)
//   clog2_min1  : index width for a requester count, never below 1 bit
//   STAT_PKT_W / STAT_TO_W : widths of the statistics counters that exist
//                            only when PERIPLEX_ARB_STATS_EN is defined
package periplex_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam int STAT_PKT_W = 16;
    localparam int STAT_TO_W  = 8;

    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpio_pkt_arbiter_rr_picker.sv
// Combinational round-robin picker: picks the first set request strictly
// after ptr_i, wrapping around, so the last winner has lowest priority.
// Ports:
//   req_i  [N]  request vector
//   ptr_i  [W]  index of the previous winner
//   gnt_o  [N]  one-hot grant (zero when nothing requests)
//   idx_o  [W]  index of the granted requester
//   any_o       at least one request is set
module rr_picker #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    always_comb begin
        int           c;
        logic [W-1:0] cw;
        c     = 0;
        cw    = '0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 1; i <= N; i++) begin
            c = int'(ptr_i) + i;
            if (c >= N) c = c - N;
            cw = W'(c);
            if (!any_o && req_i[cw]) begin
                any_o     = 1'b1;
                idx_o     = cw;
                gnt_o[cw] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_pkt_arbiter.sv
// Round-robin arbiter sharing the GPIO packet write path between NUM_REQ
// requesters, with a forced idle gap after every write strobe and a bounded
// lock for atomic multi-packet sequences.
//
// Ports:
//   clk1, rst_n          clock, synchronous active-low reset
//   req_valid/req_lock   per-requester valid and lock request
//   req_data             packed packets, requester i at slice i
//   req_ready            one-hot accept strobe (combinational)
//   dt_gpio_fifo_full    downstream backpressure, blocks all grants
//   dt_gpio_fifo_enable  one-cycle write strobe
//   dt_gpio_fifo_data    registered packet, held between strobes
//   grant_id             last accepted requester
//   lock_active, busy    lock held / FSM not idle
//   stat_pkt_cnt, stat_lock_to_cnt  only with PERIPLEX_ARB_STATS_EN defined
//
// state | meaning
// IDLE  | arbitrate; accept a packet when eligible and fifo not full
// ISSUE | drive the write strobe for one cycle
// GAP   | hold off GAP_CYCLES cycles so the clock crossing is not overrun
module gpio_pkt_arbiter
    import periplex_arb_pkg::*;
#(
    parameter int NUM_REQ           = 4,
    parameter int DATA_PACKET_WIDTH = 51,
    parameter int GAP_CYCLES        = 2,
    parameter int LOCK_TIMEOUT      = 64
) (
    input  logic                                   clk1,
    input  logic                                   rst_n,
    input  logic [NUM_REQ-1:0]                     req_valid,
    input  logic [NUM_REQ-1:0]                     req_lock,
    input  logic [NUM_REQ*DATA_PACKET_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic                                   dt_gpio_fifo_full,
    output logic                                   dt_gpio_fifo_enable,
    output logic [DATA_PACKET_WIDTH-1:0]           dt_gpio_fifo_data,
    output logic [clog2_min1(NUM_REQ)-1:0]         grant_id,
    output logic                                   lock_active,
    output logic                                   busy
`ifdef PERIPLEX_ARB_STATS_EN
    ,
    output logic [STAT_PKT_W-1:0]                  stat_pkt_cnt,
    output logic [STAT_TO_W-1:0]                   stat_lock_to_cnt
`endif
);

    localparam int            GW         = clog2_min1(NUM_REQ);
    localparam logic [3:0]    GAP_LOAD   = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [7:0]    TIMER_LAST = 8'(LOCK_TIMEOUT - 1);

    arb_state_t                   state_q, state_d;
    logic [3:0]                   gap_cnt_q, gap_cnt_d;
    logic [GW-1:0]                rr_ptr_q, gid_q, owner_q;
    logic [DATA_PACKET_WIDTH-1:0] data_q;
    logic                         lock_q;
    logic [7:0]                   timer_q;

    logic [DATA_PACKET_WIDTH-1:0] pkt [NUM_REQ];
    logic [NUM_REQ-1:0]           owner_mask, eligible, pick_gnt;
    logic [GW-1:0]                pick_idx;
    logic                         pick_any, grant_fire;
    logic                         lock_timeout, lock_release, lock_set;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pkt
        assign pkt[g] = req_data[g*DATA_PACKET_WIDTH +: DATA_PACKET_WIDTH];
    end

    assign owner_mask = NUM_REQ'(1) << owner_q;
    assign eligible   = lock_q ? (req_valid & owner_mask) : req_valid;

    rr_picker #(.N(NUM_REQ), .W(GW)) u_picker (
        .req_i (eligible),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Gating with rst_n keeps req_ready low while reset is asserted.
    assign grant_fire   = rst_n && (state_q == IDLE) && pick_any && !dt_gpio_fifo_full;
    assign lock_timeout = lock_q && (timer_q == TIMER_LAST);
    assign lock_release = lock_q && (!req_lock[owner_q] || lock_timeout);
    assign lock_set     = grant_fire && req_lock[pick_idx] && !lock_q;

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_fire) state_d = ISSUE;
            end
            ISSUE: begin
                if (GAP_CYCLES > 0) begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_q == 4'd0) state_d = IDLE;
                else                   gap_cnt_d = gap_cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready           = grant_fire ? pick_gnt : '0;
        dt_gpio_fifo_enable = (state_q == ISSUE);
        busy                = (state_q != IDLE);
    end

    // A grant to the owner in the release cycle still completes; the RR
    // pointer then sits on the owner so fairness resumes from there.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            data_q   <= '0;
            gid_q    <= '0;
            rr_ptr_q <= GW'(NUM_REQ - 1);
            lock_q   <= 1'b0;
            owner_q  <= '0;
            timer_q  <= '0;
        end else begin
            if (grant_fire) begin
                data_q   <= pkt[pick_idx];
                gid_q    <= pick_idx;
                rr_ptr_q <= pick_idx;
            end
            if (lock_q) begin
                if (lock_release) begin
                    lock_q  <= 1'b0;
                    timer_q <= '0;
                end else if (timer_q != 8'hFF) begin
                    timer_q <= timer_q + 8'd1;
                end
            end else if (lock_set) begin
                lock_q  <= 1'b1;
                owner_q <= pick_idx;
                timer_q <= '0;
            end
        end
    end

    assign dt_gpio_fifo_data = data_q;
    assign grant_id          = gid_q;
    assign lock_active       = lock_q;

`ifdef PERIPLEX_ARB_STATS_EN
    logic [STAT_PKT_W-1:0] pkt_cnt_q;
    logic [STAT_TO_W-1:0]  to_cnt_q;

    // Only a release the owner did not ask for counts as a timeout.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            pkt_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            if (dt_gpio_fifo_enable && (pkt_cnt_q != '1))
                pkt_cnt_q <= pkt_cnt_q + 1'b1;
            if (lock_timeout && req_lock[owner_q] && (to_cnt_q != '1))
                to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign stat_pkt_cnt     = pkt_cnt_q;
    assign stat_lock_to_cnt = to_cnt_q;
`else
    // Statistics not built: the timeout pulse only drives lock release.
`endif

endmodule

// File: tb/tb_gpio_pkt_arbiter.sv
// Bench for gpio_pkt_arbiter (NUM_REQ=4, GAP_CYCLES=2, LOCK_TIMEOUT=8).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_gpio_pkt_arbiter;

    localparam int NR = 4;
    localparam int DW = 51;

    localparam logic [DW-1:0] D0 = 51'h4_0000_0000_00A0;
    localparam logic [DW-1:0] D1 = 51'h0_0000_0001_2345;
    localparam logic [DW-1:0] D2 = 51'h2_FFFF_0000_1234;
    localparam logic [DW-1:0] D3 = 51'h7_FFFF_FFFF_FFFF;
    localparam logic [DW-1:0] DVAL [4] = '{D0, D1, D2, D3};

    logic             clk1 = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_lock = '0;
    logic [NR*DW-1:0] req_data = {D3, D2, D1, D0};
    logic             full = 1'b0;
    logic [NR-1:0]    req_ready;
    logic             en;
    logic [DW-1:0]    fdata;
    logic [1:0]       gid;
    logic             lock_active;
    logic             busy;
`ifdef PERIPLEX_ARB_STATS_EN
    logic [15:0]      stat_pkt_cnt;
    logic [7:0]       stat_lock_to_cnt;
`endif

    gpio_pkt_arbiter #(
        .NUM_REQ(NR), .DATA_PACKET_WIDTH(DW), .GAP_CYCLES(2), .LOCK_TIMEOUT(8)
    ) dut (
        .clk1                (clk1),
        .rst_n               (rst_n),
        .req_valid           (req_valid),
        .req_lock            (req_lock),
        .req_data            (req_data),
        .req_ready           (req_ready),
        .dt_gpio_fifo_full   (full),
        .dt_gpio_fifo_enable (en),
        .dt_gpio_fifo_data   (fdata),
        .grant_id            (gid),
        .lock_active         (lock_active),
        .busy                (busy)
`ifdef PERIPLEX_ARB_STATS_EN
        ,
        .stat_pkt_cnt        (stat_pkt_cnt),
        .stat_lock_to_cnt    (stat_lock_to_cnt)
`endif
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic          rst;
        logic [3:0]    valid;
        logic [3:0]    lock;
        logic          full;
        logic [3:0]    e_ready;
        logic          e_en;
        logic [1:0]    e_gid;
        logic          e_lock;
        logic          e_busy;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic [3:0] v, input logic [3:0] l, input logic f);
        @(negedge clk1);
        rst_n     = r;
        req_valid = v;
        req_lock  = l;
        full      = f;
        #1;
    endtask

    task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l, input logic f,
                       input logic [3:0] er, input logic ee, input logic [1:0] eg,
                       input logic el, input logic eb, input logic [DW-1:0] ed);
        vec_t t;
        t.rst = r; t.valid = v; t.lock = l; t.full = f;
        t.e_ready = er; t.e_en = ee; t.e_gid = eg; t.e_lock = el; t.e_busy = eb; t.e_data = ed;
        tbl.push_back(t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, got %0t expected below 200000", $time);
        $fatal(1);
    end

    initial begin
        // Reset held three cycles, ready gated during reset, then single requester 1.
        add(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 2'd0, 0, 0, '0);
        add(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 2'd0, 0, 0, '0);
        add(0, 4'b0010, 4'b0000, 0, 4'b0000, 0, 2'd0, 0, 0, '0);
        add(1, 4'b0010, 4'b0000, 0, 4'b0010, 0, 2'd0, 0, 0, '0);
        add(1, 4'b0000, 4'b0000, 0, 4'b0000, 1, 2'd1, 0, 1, D1);
        add(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 2'd1, 0, 1, D1);
        add(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 2'd1, 0, 1, D1);
        add(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 2'd1, 0, 0, D1);
        // Re-reset so round robin starts from requester 0.
        add(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 2'd1, 0, 0, D1);
        add(1, 4'b1111, 4'b0000, 0, 4'b0001, 0, 2'd0, 0, 0, '0);
        for (int g = 0; g < 4; g++) begin
            add(1, 4'b1111, 4'b0000, 0, 4'b0000, 1, 2'(g), 0, 1, DVAL[g]);
            add(1, 4'b1111, 4'b0000, 0, 4'b0000, 0, 2'(g), 0, 1, DVAL[g]);
            add(1, 4'b1111, 4'b0000, 0, 4'b0000, 0, 2'(g), 0, 1, DVAL[g]);
            add(1, 4'b1111, 4'b0000, 0, 4'(4'b0001 << ((g + 1) % 4)), 0, 2'(g), 0, 0, DVAL[g]);
        end
        add(1, 4'b1111, 4'b0000, 0, 4'b0000, 1, 2'd0, 0, 1, D0);
        add(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 2'd0, 0, 1, D0);
        add(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 2'd0, 0, 1, D0);
        // Backpressure: ten cycles blocked, then accept and strobe.
        for (int k = 0; k < 10; k++)
            add(1, 4'b0001, 4'b0000, 1, 4'b0000, 0, 2'd0, 0, 0, D0);
        add(1, 4'b0001, 4'b0000, 0, 4'b0001, 0, 2'd0, 0, 0, D0);
        add(1, 4'b0000, 4'b0000, 0, 4'b0000, 1, 2'd0, 0, 1, D0);

        foreach (tbl[k]) begin
            cyc(tbl[k].rst, tbl[k].valid, tbl[k].lock, tbl[k].full);
            chk($sformatf("v%0d ready", k), 64'(req_ready),   64'(tbl[k].e_ready));
            chk($sformatf("v%0d enable", k), 64'(en),         64'(tbl[k].e_en));
            chk($sformatf("v%0d grant_id", k), 64'(gid),      64'(tbl[k].e_gid));
            chk($sformatf("v%0d lock", k), 64'(lock_active),  64'(tbl[k].e_lock));
            chk($sformatf("v%0d busy", k), 64'(busy),         64'(tbl[k].e_busy));
            chk($sformatf("v%0d data", k), 64'(fdata),        64'(tbl[k].e_data));
        end

        // Lock: requester 2 sends three packets while everyone is valid.
        cyc(1, 4'b0000, 4'b0000, 0);
        chk("lk gap busy", 64'(busy), 64'd1);
        cyc(1, 4'b0000, 4'b0000, 0);
        cyc(1, 4'b0100, 4'b0100, 0);                      // A
        chk("lk A ready", 64'(req_ready), 64'b0100);
        chk("lk A lock", 64'(lock_active), 64'd0);
        cyc(1, 4'b1111, 4'b0100, 0);                      // A+1
        chk("lk A1 en", 64'(en), 64'd1);
        chk("lk A1 gid", 64'(gid), 64'd2);
        chk("lk A1 data", 64'(fdata), 64'(D2));
        chk("lk A1 lock", 64'(lock_active), 64'd1);
        cyc(1, 4'b1111, 4'b0100, 0);
        cyc(1, 4'b1111, 4'b0100, 0);
        cyc(1, 4'b1111, 4'b0100, 0);                      // A+4
        chk("lk A4 ready", 64'(req_ready), 64'b0100);
        cyc(1, 4'b1111, 4'b0100, 0);                      // A+5
        chk("lk A5 gid", 64'(gid), 64'd2);
        cyc(1, 4'b1111, 4'b0100, 0);
        cyc(1, 4'b1111, 4'b0100, 0);
        cyc(1, 4'b1111, 4'b0000, 0);                      // A+8: last packet, lock dropped
        chk("lk A8 ready", 64'(req_ready), 64'b0100);
        chk("lk A8 lock", 64'(lock_active), 64'd1);
        cyc(1, 4'b1111, 4'b0000, 0);                      // A+9
        chk("lk A9 lock", 64'(lock_active), 64'd0);
        chk("lk A9 gid", 64'(gid), 64'd2);
        cyc(1, 4'b1111, 4'b0000, 0);
        cyc(1, 4'b1111, 4'b0000, 0);
        cyc(1, 4'b1111, 4'b0000, 0);                      // A+12
        chk("lk A12 ready", 64'(req_ready), 64'b1000);
        cyc(1, 4'b0000, 4'b0000, 0);
        chk("lk A13 gid", 64'(gid), 64'd3);
        cyc(1, 4'b0000, 4'b0000, 0);
        cyc(1, 4'b0000, 4'b0000, 0);

        // Lock timeout: owner 1 keeps req_lock but stops sending.
        cyc(1, 4'b0010, 4'b0010, 0);                      // B
        chk("to B ready", 64'(req_ready), 64'b0010);
        for (int k = 1; k <= 8; k++) begin
            cyc(1, 4'b0001, 4'b0010, 0);                  // B+k
            chk($sformatf("to B%0d lock", k), 64'(lock_active), 64'd1);
            chk($sformatf("to B%0d ready", k), 64'(req_ready), 64'd0);
        end
        cyc(1, 4'b0001, 4'b0010, 0);                      // B+9
        chk("to B9 lock", 64'(lock_active), 64'd0);
        chk("to B9 ready", 64'(req_ready), 64'b0001);
`ifdef PERIPLEX_ARB_STATS_EN
        chk("to stat_lock_to_cnt", 64'(stat_lock_to_cnt), 64'd1);
        chk("to stat_pkt_cnt", 64'(stat_pkt_cnt), 64'd11);
`endif
        cyc(1, 4'b0000, 4'b0000, 0);                      // B+10
        chk("to B10 en", 64'(en), 64'd1);
        chk("to B10 data", 64'(fdata), 64'(D0));

        // Reset during GAP.
        cyc(0, 4'b0000, 4'b0000, 0);                      // B+11, still GAP
        chk("rs gap busy", 64'(busy), 64'd1);
        cyc(1, 4'b1111, 4'b0000, 0);                      // B+12
        chk("rs busy", 64'(busy), 64'd0);
        chk("rs en", 64'(en), 64'd0);
        chk("rs gid", 64'(gid), 64'd0);
        chk("rs data", 64'(fdata), 64'd0);
        chk("rs lock", 64'(lock_active), 64'd0);
        chk("rs ready", 64'(req_ready), 64'b0001);
`ifdef PERIPLEX_ARB_STATS_EN
        chk("rs stat_pkt_cnt", 64'(stat_pkt_cnt), 64'd0);
        chk("rs stat_lock_to_cnt", 64'(stat_lock_to_cnt), 64'd0);
`endif
        cyc(1, 4'b0000, 4'b0000, 0);                      // B+13
        chk("rs en after", 64'(en), 64'd1);
        chk("rs data after", 64'(fdata), 64'(D0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
